// File: rtl/core_multicycle_controller_if.sv
// Unified instruction/data memory handshake between the controller and memory.
// The controller issues requests; memory answers with mem_ready when the access completes.
interface core_multicycle_controller_if;
   logic mem_req;
   logic mem_write;
   logic iord;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_write,
      output iord,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_write,
      input  iord,
      output mem_ready
   );
endinterface

// File: rtl/core_multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath, with a
// retired-instruction counter for bring-up.
module core_multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [5:0]                    opcode,
   input  logic [5:0]                    funct,
   input  logic                          zero,
   core_multicycle_controller_if.master  mem,
   output logic                          ir_write,
   output logic                          pc_en,
   output logic                          reg_write,
   output logic                          reg_dest,
   output logic                          mem_to_reg,
   output logic                          alu_src_a,
   output logic [1:0]                    alu_src_b,
   output logic [1:0]                    pc_src,
   output logic [2:0]                    alu_ctrl,
   output logic                          illegal_instr,
   output logic [3:0]                    state,
   output logic [CNT_W-1:0]              instr_count
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_en;
      logic       reg_write;
      logic       reg_dest;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_ctrl;
      logic       illegal_instr;
   } ctrl_t;

   state_t             state_reg;
   state_t             state_next;
   ctrl_t              ctrl_next;
   ctrl_t              ctrl;
   logic               retire_next;
   logic [CNT_W-1:0]   count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (retire_next) begin
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_next         = state_reg;
      ctrl_next          = '0;
      ctrl_next.alu_ctrl = ALU_ADD;
      retire_next        = 1'b0;
      case (state_reg)
         S_FETCH: begin
            ctrl_next.mem_req   = 1'b1;
            ctrl_next.alu_src_b = 2'b01;
            ctrl_next.ir_write  = mem.mem_ready;
            ctrl_next.pc_en     = mem.mem_ready;
            if (mem.mem_ready) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            ctrl_next.alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default: begin
                  ctrl_next.illegal_instr = 1'b1;
                  state_next              = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctrl_next.alu_src_a = 1'b1;
            ctrl_next.alu_src_b = 2'b10;
            state_next          = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctrl_next.mem_req = 1'b1;
            ctrl_next.iord    = 1'b1;
            if (mem.mem_ready) begin
               state_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            ctrl_next.reg_write  = 1'b1;
            ctrl_next.mem_to_reg = 1'b1;
            retire_next          = 1'b1;
            state_next           = S_FETCH;
         end
         S_MEMWR: begin
            ctrl_next.mem_req   = 1'b1;
            ctrl_next.mem_write = 1'b1;
            ctrl_next.iord      = 1'b1;
            if (mem.mem_ready) begin
               retire_next = 1'b1;
               state_next  = S_FETCH;
            end
         end
         S_EXECUTE: begin
            ctrl_next.alu_src_a = 1'b1;
            state_next          = S_ALUWB;
            case (funct)
               6'b100000: ctrl_next.alu_ctrl = ALU_ADD;
               6'b100010: ctrl_next.alu_ctrl = ALU_SUB;
               6'b100100: ctrl_next.alu_ctrl = ALU_AND;
               6'b100101: ctrl_next.alu_ctrl = ALU_OR;
               6'b101010: ctrl_next.alu_ctrl = ALU_SLT;
               default: begin
                  ctrl_next.illegal_instr = 1'b1;
                  state_next              = S_FETCH;
               end
            endcase
         end
         S_ALUWB: begin
            ctrl_next.reg_write = 1'b1;
            ctrl_next.reg_dest  = 1'b1;
            retire_next         = 1'b1;
            state_next          = S_FETCH;
         end
         S_BRANCH: begin
            ctrl_next.alu_src_a = 1'b1;
            ctrl_next.alu_ctrl  = ALU_SUB;
            ctrl_next.pc_src    = 2'b01;
            ctrl_next.pc_en     = zero;
            retire_next         = 1'b1;
            state_next          = S_FETCH;
         end
         S_ADDIEX: begin
            ctrl_next.alu_src_a = 1'b1;
            ctrl_next.alu_src_b = 2'b10;
            state_next          = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl_next.reg_write = 1'b1;
            retire_next         = 1'b1;
            state_next          = S_FETCH;
         end
         S_JUMP: begin
            ctrl_next.pc_src = 2'b10;
            ctrl_next.pc_en  = 1'b1;
            retire_next      = 1'b1;
            state_next       = S_FETCH;
         end
         default: begin
            // Unreachable encodings recover to FETCH with every output quiet.
            ctrl_next  = '0;
            state_next = S_FETCH;
         end
      endcase
   end

   // Reset silences every control line, even while the state register is unknown.
   assign ctrl = reset ? '0 : ctrl_next;

   assign mem.mem_req    = ctrl.mem_req;
   assign mem.mem_write  = ctrl.mem_write;
   assign mem.iord       = ctrl.iord;
   assign ir_write       = ctrl.ir_write;
   assign pc_en          = ctrl.pc_en;
   assign reg_write      = ctrl.reg_write;
   assign reg_dest       = ctrl.reg_dest;
   assign mem_to_reg     = ctrl.mem_to_reg;
   assign alu_src_a      = ctrl.alu_src_a;
   assign alu_src_b      = ctrl.alu_src_b;
   assign pc_src         = ctrl.pc_src;
   assign alu_ctrl       = ctrl.alu_ctrl;
   assign illegal_instr  = ctrl.illegal_instr;
   assign state          = state_reg;
   assign instr_count    = count_reg;

endmodule

// File: tb/tb_core_multicycle_controller.sv
// Randomized self-checking bench: each instruction is compared against a
// transaction-level model of its state path, pulse counts and retire count.
module tb_core_multicycle_controller;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             ir_write, pc_en, reg_write, reg_dest, mem_to_reg, alu_src_a;
   logic [1:0]       alu_src_b, pc_src;
   logic [2:0]       alu_ctrl;
   logic             illegal_instr;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;

   core_multicycle_controller_if mbus ();

   core_multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem           (mbus.master),
      .ir_write      (ir_write),
      .pc_en         (pc_en),
      .reg_write     (reg_write),
      .reg_dest      (reg_dest),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .pc_src        (pc_src),
      .alu_ctrl      (alu_ctrl),
      .illegal_instr (illegal_instr),
      .state         (state),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int model_count = 0;
   int wcnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit funct_ok(input logic [5:0] f);
      return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
             f == 6'b100101 || f == 6'b101010;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Reset for n cycles (entered just after a rising edge); control must stay silent.
   task automatic do_reset(input int n);
      logic [19:0] ctrl_all;
      reset = 1'b1;
      mbus.mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ctrl_all = {mbus.mem_req, mbus.mem_write, mbus.iord, ir_write, pc_en, reg_write,
                     reg_dest, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
                     illegal_instr, 3'b000};
         check("rst_ctrl", 32'(ctrl_all), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      model_count = 0;
      wcnt = 0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_mem_req", 32'(mbus.mem_req), 32'd1);
      check("rst_iord", 32'(mbus.iord), 32'd0);
      $display("reset %0d cycles", n);
   endtask

   // Run one instruction; wf/wm are wait cycles on the fetch and data accesses.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm);
      int  path[$];
      bit  is_lw, is_sw, is_r, is_beq, is_addi, is_j, r_ok, illegal;
      int  n_ir, n_pc, n_rw, n_mw, n_il;
      int  exp_pc, exp_rw, exp_mw;
      int  need;
      is_lw   = (op == 6'b100011);
      is_sw   = (op == 6'b101011);
      is_r    = (op == 6'b000000);
      is_beq  = (op == 6'b000100);
      is_addi = (op == 6'b001000);
      is_j    = (op == 6'b000010);
      r_ok    = is_r && funct_ok(fn);
      illegal = !(is_lw || is_sw || is_r || is_beq || is_addi || is_j) || (is_r && !r_ok);

      for (int i = 0; i <= wf; i++) path.push_back(0);
      path.push_back(1);
      if (is_lw) begin
         path.push_back(2);
         for (int i = 0; i <= wm; i++) path.push_back(3);
         path.push_back(4);
      end else if (is_sw) begin
         path.push_back(2);
         for (int i = 0; i <= wm; i++) path.push_back(5);
      end else if (is_r) begin
         path.push_back(6);
         if (r_ok) path.push_back(7);
      end else if (is_beq) begin
         path.push_back(8);
      end else if (is_addi) begin
         path.push_back(9);
         path.push_back(10);
      end else if (is_j) begin
         path.push_back(11);
      end

      exp_pc = 1 + (is_j ? 1 : 0) + ((is_beq && z) ? 1 : 0);
      exp_rw = (is_lw || r_ok || is_addi) ? 1 : 0;
      exp_mw = is_sw ? wm + 1 : 0;
      n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_il = 0;

      opcode = op;
      funct  = fn;
      zero   = z;
      for (int i = 0; i < path.size(); i++) begin
         need = mbus.iord ? wm : wf;
         if (mbus.mem_req) mbus.mem_ready = (wcnt >= need);
         else              mbus.mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("state", 32'(state), 32'(path[i]));
         if (ir_write) n_ir++;
         if (pc_en) n_pc++;
         if (illegal_instr) n_il++;
         if (reg_write) begin
            n_rw++;
            check("mem_to_reg", 32'(mem_to_reg), 32'(is_lw));
            check("reg_dest", 32'(reg_dest), 32'(r_ok));
         end
         if (mbus.mem_write) begin
            n_mw++;
            check("mw_iord", 32'({mbus.mem_req, mbus.iord}), 32'd3);
         end
         if (path[i] == 0) check("fetch_bus", 32'({mbus.mem_req, mbus.iord}), 32'd2);
         if (path[i] == 6 && r_ok) check("alu_ctrl", 32'(alu_ctrl), 32'(alu_of(fn)));
         if (path[i] == 8) check("br_pc", 32'({pc_src, pc_en}), 32'({2'b01, z}));
         if (mbus.mem_req) wcnt = mbus.mem_ready ? 0 : wcnt + 1;
         @(posedge clk);
         #1;
      end
      if (!illegal) model_count = (model_count + 1) % (1 << CNT_W);
      check("ir_write_n", 32'(n_ir), 32'd1);
      check("pc_en_n", 32'(n_pc), 32'(exp_pc));
      check("reg_write_n", 32'(n_rw), 32'(exp_rw));
      check("mem_write_n", 32'(n_mw), 32'(exp_mw));
      check("illegal_n", 32'(n_il), 32'(illegal));
      check("count", 32'(instr_count), 32'(model_count));
      $display("instr op=%b funct=%b zero=%0d wf=%0d wm=%0d cycles=%0d count=%0d",
               op, fn, z, wf, wm, path.size(), instr_count);
   endtask

   initial begin
      logic [5:0] fvals[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] ops[7]   = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b000010, 6'b111111};
      logic [5:0] bad_ops[3] = '{6'b111111, 6'b000011, 6'b001101};
      logic [5:0] op, fn;
      int sel;

      reset = 1'b1;
      opcode = '0;
      funct = '0;
      zero = 1'b0;
      mbus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);

      run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b101011, 6'b000000, 1'b0, 2, 3);
      for (int i = 0; i < 5; i++) run_instr(6'b000000, fvals[i], 1'b0, 0, 0);
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);

      // Abandon an lw part-way through, then reset again.
      opcode = 6'b100011;
      mbus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_reset(3);

      // Enough jumps to wrap the 4-bit counter.
      for (int i = 0; i < 20; i++) run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);

      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 6);
         op  = (sel == 6) ? bad_ops[$urandom_range(0, 2)] : ops[sel];
         fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                           : fvals[$urandom_range(0, 4)];
         run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/core_multicycle_controller.md
Name: core_multicycle_controller

Overview:
Moore-style control FSM that sequences a shared-memory multicycle MIPS datapath. It owns the datapath's register enables, mux selects and ALU function code. It handshakes with a single unified instruction/data memory that may insert wait states. It also keeps a retired-instruction counter for bring-up and debug.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
opcode  in  6  instr[31:26] from instruction register (stable after FETCH)
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  access is a write (valid only with mem_req)
iord  out  1  memory address select: 0=PC, 1=ALU result register
ir_write  out  1  instruction register enable
pc_en  out  1  PC register enable (pc_write | branch&zero)
reg_write  out  1  register file write enable
reg_dest  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  writeback: 0=ALU result register, 1=memory data register
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=constant 4, 10=sign_imm, 11=sign_imm<<2
pc_src  out  2  00=ALU result, 01=ALU result register (branch target), 10=jump target
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset: state=FETCH, instr_count=0. While reset=1, every control output is 0, including mem_req, pc_en and reg_write. Reset mid-instruction abandons that instruction. No write is issued in the reset cycle.
- Outputs are combinational from state, plus mem_ready, zero, opcode and funct where noted. All unlisted outputs are 0. alu_ctrl defaults to 010.
- States and encodings:
  - FETCH (0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, add. ir_write=pc_en=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): alu_src_a=0, alu_src_b=11, add (branch target). Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> illegal_instr=1, then FETCH.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_req=1, iord=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB (4): reg_write=1, reg_dest=0, mem_to_reg=1. Goes to FETCH.
  - MEMWR (5): mem_req=1, mem_write=1, iord=1. Held until mem_ready; memory commits in that cycle. Then goes to FETCH.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Known funct -> ALUWB. Unknown funct -> illegal_instr=1, no writeback, then FETCH.
  - ALUWB (7): reg_write=1, reg_dest=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Goes to FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
  - ADDIWB (10): reg_write=1, reg_dest=0, mem_to_reg=0. Goes to FETCH.
  - JUMP (11): pc_src=10, pc_en=1. Goes to FETCH.
- Encodings 12-15 are unreachable. If one is entered, the FSM goes to FETCH on the next edge and drives all outputs 0.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memory wait cycle adds 1 cycle. mem_req, mem_write and iord stay constant while waiting. pc_en and ir_write stay 0 until mem_ready=1.
- instr_count increments by 1 on the clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. Illegal instructions do not increment it. The counter wraps from all-ones to 0.

Test Plan:
- Reset: hold reset for 3 cycles from an arbitrary state, mid-lw -> state=0, instr_count=0, all enables 0 during reset. First post-reset cycle has mem_req=1, iord=0.
- lw (opcode 100011), mem_ready tied 1 -> states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1, reg_dest=0 only in state 4. instr_count=1.
- sw with 2 wait cycles in FETCH and 3 in MEMWR -> ir_write and pc_en pulse only on the FETCH mem_ready cycle. mem_write=1 for exactly 4 cycles. Total 9 cycles. reg_write never 1.
- R-type funct sequence 100000,100010,100100,100101,101010 -> alu_ctrl 010,110,000,001,111 in EXECUTE. ALUWB has reg_dest=1.
- beq with zero=1 then zero=0 -> pc_en=1 with pc_src=01 in the first case. pc_en=0 in the second. 3 cycles each.
- Illegal opcode 111111 and R-type funct 000111 -> one-cycle illegal_instr pulse, return to FETCH, instr_count unchanged, no reg_write. Also preload a counter of all-ones via a run of j instructions at CNT_W=4 -> wraps to 0.
